// File: rtl/safe_pkg.sv
// Shared types and status encodings for the safe combination-lock controller.
package safe_pkg;

  typedef enum logic [2:0] {
    LOCKED,
    ENTRY,
    OPEN,
    WRONG,
    LOCKOUT
  } state_t;

  typedef logic [1:0] status_t;

  localparam status_t ST_LOCKED  = 2'b00;
  localparam status_t ST_OPEN    = 2'b01;
  localparam status_t ST_WRONG   = 2'b10;
  localparam status_t ST_LOCKOUT = 2'b11;

  // Digit idx of a packed 4-digit code; digit 0 lives in [1:0].
  function automatic logic [1:0] code_digit(input logic [7:0] code, input logic [1:0] idx);
    return code[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/safe_lock_fsm_if.sv
// Button and status bundle between the keypad side and the lock controller.
interface safe_lock_fsm_if;
  import safe_pkg::*;

  logic [3:0] key;
  status_t    ctrl;
  logic       enable;
  logic [2:0] digits;

  modport master (output key, input ctrl, input enable, input digits);
  modport slave  (input key, output ctrl, output enable, output digits);

endinterface

// File: rtl/key_edge.sv
// Rising-edge detector over the four synchronized key levels.
module key_edge (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_i,
  output logic       press_o,
  output logic [1:0] digit_o,
  output logic       multi_o
);

  logic [3:0] hist_q;
  logic [3:0] rise;

  // History follows key every cycle; reset also loads key so a held key is not a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= key_i;
    end else begin
      hist_q <= key_i;
    end
  end

  // Per-bit rising edge, encoded digit, and a flag for simultaneous rises.
  always_comb begin
    rise    = key_i & ~hist_q;
    press_o = |rise;
    multi_o = (rise & (rise - 4'd1)) != 4'd0;
    digit_o = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) digit_o = 2'(i);
    end
  end

endmodule

// File: rtl/safe_lock_fsm.sv
// Combination-lock controller: collects four digits, checks the secret,
// tracks failed attempts and drives a registered status plus change strobe.
module safe_lock_fsm
  import safe_pkg::*;
#(
  parameter logic [7:0]  CODE         = 8'b11_10_01_00,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned WRONG_CYCLES = 50_000_000,
  parameter int unsigned LOCK_CYCLES  = 500_000_000,
  parameter int unsigned TIMEOUT      = 250_000_000
) (
  input  logic            clk,
  input  logic            reset,
  safe_lock_fsm_if.slave  bus
);

  localparam int unsigned MaxA = (TIMEOUT > WRONG_CYCLES) ? TIMEOUT : WRONG_CYCLES;
  localparam int unsigned MaxCycles = (MaxA > LOCK_CYCLES) ? MaxA : LOCK_CYCLES;
  localparam int unsigned TW = $clog2(MaxCycles) + 1;
  localparam int unsigned FW = $clog2(MAX_TRIES) + 1;
  // fail + 1 < MAX_TRIES  <=>  fail < MAX_TRIES - 1
  localparam logic [FW-1:0] FailLimit = FW'(MAX_TRIES - 1);

  state_t          state_q;
  status_t         ctrl_q;
  logic            enable_q;
  logic [2:0]      digits_q;
  logic [FW-1:0]   fail_q;
  logic [TW-1:0]   timer_q;
  logic            mismatch_q;

  logic            press;
  logic [1:0]      digit;
  logic            multi;
  logic            digit_mis;
  logic            final_mis;

  key_edge u_key_edge (
    .clk     (clk),
    .reset   (reset),
    .key_i   (bus.key),
    .press_o (press),
    .digit_o (digit),
    .multi_o (multi)
  );

  // Compare the incoming digit with the secret at the current position.
  always_comb begin
    digit_mis = multi | (digit != code_digit(CODE, digits_q[1:0]));
    final_mis = mismatch_q | digit_mis;
  end

  // Lock state machine; ctrl/enable are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOCKED;
      ctrl_q     <= ST_LOCKED;
      enable_q   <= 1'b0;
      digits_q   <= 3'd0;
      fail_q     <= '0;
      timer_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      enable_q <= 1'b0;
      unique case (state_q)
        LOCKED: begin
          if (press) begin
            state_q    <= ENTRY;
            digits_q   <= 3'd1;
            mismatch_q <= digit_mis;
            timer_q    <= TW'(TIMEOUT);
          end
        end
        ENTRY: begin
          if (press) begin
            if (digits_q == 3'd3) begin
              digits_q   <= 3'd0;
              mismatch_q <= 1'b0;
              enable_q   <= 1'b1;
              if (!final_mis) begin
                state_q <= OPEN;
                ctrl_q  <= ST_OPEN;
                fail_q  <= '0;
              end else if (fail_q < FailLimit) begin
                state_q <= WRONG;
                ctrl_q  <= ST_WRONG;
                fail_q  <= fail_q + 1'b1;
                timer_q <= TW'(WRONG_CYCLES);
              end else begin
                state_q <= LOCKOUT;
                ctrl_q  <= ST_LOCKOUT;
                fail_q  <= '0;
                timer_q <= TW'(LOCK_CYCLES);
              end
            end else begin
              digits_q   <= digits_q + 3'd1;
              mismatch_q <= final_mis;
              timer_q    <= TW'(TIMEOUT);
            end
          end else if (timer_q <= TW'(1)) begin
            // Abandoned entry: silent return, fail count untouched.
            state_q    <= LOCKED;
            digits_q   <= 3'd0;
            mismatch_q <= 1'b0;
            timer_q    <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        OPEN: begin
          if (press) begin
            state_q  <= LOCKED;
            ctrl_q   <= ST_LOCKED;
            enable_q <= 1'b1;
          end
        end
        WRONG, LOCKOUT: begin
          if (timer_q <= TW'(1)) begin
            state_q  <= LOCKED;
            ctrl_q   <= ST_LOCKED;
            enable_q <= 1'b1;
            timer_q  <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q <= LOCKED;
          ctrl_q  <= ST_LOCKED;
        end
      endcase
    end
  end

  assign bus.ctrl   = ctrl_q;
  assign bus.enable = enable_q;
  assign bus.digits = digits_q;

endmodule

// File: tb/tb_safe_lock_fsm.sv
// Directed bench for safe_lock_fsm with short timer parameters.
module tb_safe_lock_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   en_cnt = 0;

  localparam logic [7:0] Good = 8'b11_10_01_00;
  localparam logic [7:0] Bad  = 8'b11_11_11_11;

  safe_lock_fsm_if lock_if ();

  safe_lock_fsm #(
    .CODE         (Good),
    .MAX_TRIES    (3),
    .WRONG_CYCLES (4),
    .LOCK_CYCLES  (8),
    .TIMEOUT      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (lock_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (lock_if.enable === 1'b1) en_cnt++;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] k);
    lock_if.key = k;
    cyc(2);
    lock_if.key = 4'b0000;
    cyc(2);
  endtask

  task automatic enter_code(input logic [7:0] c);
    for (int i = 0; i < 4; i++) press(4'b0001 << c[2*i +: 2]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    lock_if.key = 4'b0000;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lock_if.key = 4'b0001;
    cyc(2);
    n_checks++; if (lock_if.ctrl !== 2'b00) begin n_fail++;
      $display("FAIL reset_ctrl: got %b want 00", lock_if.ctrl); end
    n_checks++; if (lock_if.enable !== 1'b0) begin n_fail++;
      $display("FAIL reset_enable: got %b want 0", lock_if.enable); end
    n_checks++; if (lock_if.digits !== 3'd0) begin n_fail++;
      $display("FAIL reset_digits: got %0d want 0", lock_if.digits); end
    reset = 1'b0;
    cyc(2);
    n_checks++; if (lock_if.digits !== 3'd0) begin n_fail++;
      $display("FAIL held_key_through_reset: digits got %0d want 0", lock_if.digits); end
    lock_if.key = 4'b0000;
    cyc(2);
  endtask

  task automatic test_open();
    int en0;
    en0 = en_cnt;
    press(4'b0001);
    n_checks++; if (lock_if.digits !== 3'd1) begin n_fail++;
      $display("FAIL open_digits1: got %0d want 1", lock_if.digits); end
    press(4'b0010);
    n_checks++; if (lock_if.digits !== 3'd2) begin n_fail++;
      $display("FAIL open_digits2: got %0d want 2", lock_if.digits); end
    press(4'b0100);
    n_checks++; if (lock_if.digits !== 3'd3) begin n_fail++;
      $display("FAIL open_digits3: got %0d want 3", lock_if.digits); end
    n_checks++; if (en_cnt !== en0) begin n_fail++;
      $display("FAIL entry_no_enable: pulses got %0d want 0", en_cnt - en0); end
    lock_if.key = 4'b1000;
    cyc(1);
    n_checks++; if (lock_if.ctrl !== 2'b01) begin n_fail++;
      $display("FAIL open_ctrl: got %b want 01", lock_if.ctrl); end
    n_checks++; if (lock_if.enable !== 1'b1) begin n_fail++;
      $display("FAIL open_enable: got %b want 1", lock_if.enable); end
    n_checks++; if (lock_if.digits !== 3'd0) begin n_fail++;
      $display("FAIL open_digits0: got %0d want 0", lock_if.digits); end
    cyc(1);
    n_checks++; if (lock_if.enable !== 1'b0) begin n_fail++;
      $display("FAIL open_enable_one_cycle: got %b want 0", lock_if.enable); end
    lock_if.key = 4'b0000;
    cyc(2);
    lock_if.key = 4'b0001;
    cyc(1);
    n_checks++; if (lock_if.ctrl !== 2'b00) begin n_fail++;
      $display("FAIL relock_ctrl: got %b want 00", lock_if.ctrl); end
    n_checks++; if (lock_if.enable !== 1'b1) begin n_fail++;
      $display("FAIL relock_enable: got %b want 1", lock_if.enable); end
    lock_if.key = 4'b0000;
    cyc(3);
    n_checks++; if (lock_if.digits !== 3'd0) begin n_fail++;
      $display("FAIL relock_not_digit: got %0d want 0", lock_if.digits); end
  endtask

  task automatic test_wrong();
    press(4'b0001);
    press(4'b0010);
    press(4'b1000);
    lock_if.key = 4'b1000;
    cyc(1);
    n_checks++; if (lock_if.ctrl !== 2'b10) begin n_fail++;
      $display("FAIL wrong_ctrl: got %b want 10", lock_if.ctrl); end
    n_checks++; if (lock_if.enable !== 1'b1) begin n_fail++;
      $display("FAIL wrong_enable: got %b want 1", lock_if.enable); end
    lock_if.key = 4'b0000;
    cyc(1);
    n_checks++; if (lock_if.ctrl !== 2'b10 || lock_if.enable !== 1'b0) begin n_fail++;
      $display("FAIL wrong_hold1: got ctrl %b en %b want 10/0", lock_if.ctrl, lock_if.enable); end
    lock_if.key = 4'b0001;
    cyc(1);
    n_checks++; if (lock_if.ctrl !== 2'b10 || lock_if.digits !== 3'd0) begin n_fail++;
      $display("FAIL wrong_ignore_press: got ctrl %b digits %0d want 10/0", lock_if.ctrl,
               lock_if.digits); end
    lock_if.key = 4'b0000;
    cyc(1);
    n_checks++; if (lock_if.ctrl !== 2'b10) begin n_fail++;
      $display("FAIL wrong_hold3: got %b want 10", lock_if.ctrl); end
    cyc(1);
    n_checks++; if (lock_if.ctrl !== 2'b00 || lock_if.enable !== 1'b1) begin n_fail++;
      $display("FAIL wrong_exit: got ctrl %b en %b want 00/1", lock_if.ctrl, lock_if.enable); end
    cyc(2);
    n_checks++; if (lock_if.digits !== 3'd0) begin n_fail++;
      $display("FAIL wrong_late_press: digits got %0d want 0", lock_if.digits); end
  endtask

  task automatic test_lockout();
    do_reset();
    for (int n = 0; n < 2; n++) begin
      enter_code(Bad);
      n_checks++; if (lock_if.ctrl !== 2'b10) begin n_fail++;
        $display("FAIL lockout_pre_wrong%0d: got %b want 10", n, lock_if.ctrl); end
      cyc(2);
    end
    press(4'b1000);
    press(4'b1000);
    press(4'b1000);
    lock_if.key = 4'b1000;
    cyc(1);
    n_checks++; if (lock_if.ctrl !== 2'b11 || lock_if.enable !== 1'b1) begin n_fail++;
      $display("FAIL lockout_enter: got ctrl %b en %b want 11/1", lock_if.ctrl, lock_if.enable); end
    lock_if.key = 4'b0000;
    for (int i = 1; i < 8; i++) begin
      if (i == 2) lock_if.key = 4'b0100;
      if (i == 4) lock_if.key = 4'b0000;
      cyc(1);
      n_checks++; if (lock_if.ctrl !== 2'b11) begin n_fail++;
        $display("FAIL lockout_hold%0d: got %b want 11", i, lock_if.ctrl); end
    end
    cyc(1);
    n_checks++; if (lock_if.ctrl !== 2'b00 || lock_if.enable !== 1'b1) begin n_fail++;
      $display("FAIL lockout_exit: got ctrl %b en %b want 00/1", lock_if.ctrl, lock_if.enable); end
    cyc(1);
    enter_code(Good);
    n_checks++; if (lock_if.ctrl !== 2'b01) begin n_fail++;
      $display("FAIL lockout_then_open: got %b want 01", lock_if.ctrl); end
    press(4'b0001);
    n_checks++; if (lock_if.ctrl !== 2'b00) begin n_fail++;
      $display("FAIL lockout_relock: got %b want 00", lock_if.ctrl); end
  endtask

  task automatic test_timeout();
    int en0;
    enter_code(Bad);
    cyc(2);
    en0 = en_cnt;
    press(4'b0001);
    cyc(12);
    n_checks++; if (lock_if.digits !== 3'd1) begin n_fail++;
      $display("FAIL timeout_early: digits got %0d want 1", lock_if.digits); end
    cyc(1);
    n_checks++; if (lock_if.digits !== 3'd0 || lock_if.ctrl !== 2'b00) begin n_fail++;
      $display("FAIL timeout_expire: got digits %0d ctrl %b want 0/00", lock_if.digits,
               lock_if.ctrl); end
    cyc(1);
    n_checks++; if (en_cnt !== en0) begin n_fail++;
      $display("FAIL timeout_no_enable: pulses got %0d want 0", en_cnt - en0); end
    enter_code(Bad);
    n_checks++; if (lock_if.ctrl !== 2'b10) begin n_fail++;
      $display("FAIL timeout_fail_kept: got %b want 10", lock_if.ctrl); end
    cyc(2);
    enter_code(Good);
    n_checks++; if (lock_if.ctrl !== 2'b01) begin n_fail++;
      $display("FAIL timeout_then_open: got %b want 01", lock_if.ctrl); end
    press(4'b0001);
  endtask

  task automatic test_multi();
    press(4'b0011);
    n_checks++; if (lock_if.digits !== 3'd1) begin n_fail++;
      $display("FAIL multi_counts: digits got %0d want 1", lock_if.digits); end
    press(4'b0010);
    press(4'b0100);
    press(4'b1000);
    n_checks++; if (lock_if.ctrl !== 2'b10) begin n_fail++;
      $display("FAIL multi_wrong: got %b want 10", lock_if.ctrl); end
    lock_if.key = 4'b0001;
    cyc(1);
    n_checks++; if (lock_if.ctrl !== 2'b00 || lock_if.enable !== 1'b1) begin n_fail++;
      $display("FAIL multi_exit: got ctrl %b en %b want 00/1", lock_if.ctrl, lock_if.enable); end
    cyc(3);
    n_checks++; if (lock_if.digits !== 3'd0) begin n_fail++;
      $display("FAIL held_key_no_press: digits got %0d want 0", lock_if.digits); end
    lock_if.key = 4'b0000;
    cyc(2);
  endtask

  task automatic test_reset_mid();
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    reset = 1'b1;
    cyc(1);
    n_checks++; if (lock_if.ctrl !== 2'b00 || lock_if.enable !== 1'b0 ||
                    lock_if.digits !== 3'd0) begin n_fail++;
      $display("FAIL reset_mid_entry: got ctrl %b en %b digits %0d want 00/0/0", lock_if.ctrl,
               lock_if.enable, lock_if.digits); end
    reset = 1'b0;
    cyc(1);
    for (int n = 0; n < 2; n++) begin
      enter_code(Bad);
      n_checks++; if (lock_if.ctrl !== 2'b10) begin n_fail++;
        $display("FAIL reset_clears_fail%0d: got %b want 10", n, lock_if.ctrl); end
      cyc(2);
    end
    enter_code(Bad);
    n_checks++; if (lock_if.ctrl !== 2'b11) begin n_fail++;
      $display("FAIL reset_pre_lockout: got %b want 11", lock_if.ctrl); end
    reset = 1'b1;
    cyc(1);
    n_checks++; if (lock_if.ctrl !== 2'b00 || lock_if.enable !== 1'b0 ||
                    lock_if.digits !== 3'd0) begin n_fail++;
      $display("FAIL reset_mid_lockout: got ctrl %b en %b digits %0d want 00/0/0", lock_if.ctrl,
               lock_if.enable, lock_if.digits); end
    reset = 1'b0;
    cyc(1);
    enter_code(Bad);
    n_checks++; if (lock_if.ctrl !== 2'b10) begin n_fail++;
      $display("FAIL reset_lockout_fail0: got %b want 10", lock_if.ctrl); end
    cyc(2);
  endtask

  initial begin
    lock_if.key = 4'b0000;
    test_reset();
    test_open();
    test_wrong();
    test_lockout();
    test_timeout();
    test_multi();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
